// File: rtl/imul_mul_arbiter.sv
// Round-robin arbiter sharing one registered integer multiplier between two
// val/rdy requesters. One transaction is in flight at a time: IDLE -> CALC -> WAIT.
module imul_mul_arbiter #(
    parameter int nbits = 32
) (
    input  logic               clk,
    input  logic               reset,

    input  logic               req0_val,
    output logic               req0_rdy,
    input  logic [2*nbits-1:0] req0_msg,

    input  logic               req1_val,
    output logic               req1_rdy,
    input  logic [2*nbits-1:0] req1_msg,

    output logic               resp0_val,
    input  logic               resp0_rdy,
    output logic [nbits-1:0]   resp0_msg,

    output logic               resp1_val,
    input  logic               resp1_rdy,
    output logic [nbits-1:0]   resp1_msg,

    output logic [nbits-1:0]   mul_in0,
    output logic [nbits-1:0]   mul_in1,
    input  logic [nbits-1:0]   mul_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t           state;
    logic             prio;
    logic             grant_id;
    logic [nbits-1:0] result;

    logic             grant_valid;
    logic             winner;
    logic             resp_fire;

    // Grant is only offered in IDLE; on contention prio picks the winner.
    always_comb begin
        grant_valid = 1'b0;
        winner      = 1'b0;
        if (state == IDLE) begin
            if (req0_val && req1_val) begin
                grant_valid = 1'b1;
                winner      = prio;
            end else if (req0_val) begin
                grant_valid = 1'b1;
                winner      = 1'b0;
            end else if (req1_val) begin
                grant_valid = 1'b1;
                winner      = 1'b1;
            end
        end
    end

    assign req0_rdy = grant_valid && !winner;
    assign req1_rdy = grant_valid &&  winner;

    // Operands only reach the multiplier in the grant cycle; it registers them itself.
    always_comb begin
        mul_in0 = '0;
        mul_in1 = '0;
        if (grant_valid) begin
            if (winner) begin
                mul_in0 = req1_msg[2*nbits-1:nbits];
                mul_in1 = req1_msg[nbits-1:0];
            end else begin
                mul_in0 = req0_msg[2*nbits-1:nbits];
                mul_in1 = req0_msg[nbits-1:0];
            end
        end
    end

    assign resp0_val = (state == WAIT) && !grant_id;
    assign resp1_val = (state == WAIT) &&  grant_id;
    assign resp0_msg = result;
    assign resp1_msg = result;

    assign resp_fire = (resp0_val && resp0_rdy) || (resp1_val && resp1_rdy);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            prio     <= 1'b0;
            grant_id <= 1'b0;
            result   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        grant_id <= winner;
                        prio     <= ~winner;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    result <= mul_out;
                    state  <= WAIT;
                end
                WAIT: begin
                    if (resp_fire) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imul_mul_arbiter.sv
// Directed self-checking bench for imul_mul_arbiter; models the registered
// multiplier and checks grants, products, backpressure and reset behaviour.
module tb_imul_mul_arbiter;

    localparam int NBITS = 32;

    logic               clk = 1'b0;
    logic               reset;
    logic               req0_val, req1_val;
    logic               req0_rdy, req1_rdy;
    logic [2*NBITS-1:0] req0_msg, req1_msg;
    logic               resp0_val, resp1_val;
    logic               resp0_rdy, resp1_rdy;
    logic [NBITS-1:0]   resp0_msg, resp1_msg;
    logic [NBITS-1:0]   mul_in0, mul_in1;
    logic [NBITS-1:0]   mul_out;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    // Stand-in for the real multiplier: product of last cycle's operands.
    always @(posedge clk) begin
        mul_out <= mul_in0 * mul_in1;
    end

    imul_mul_arbiter #(.nbits(NBITS)) dut (
        .clk       (clk),
        .reset     (reset),
        .req0_val  (req0_val),
        .req0_rdy  (req0_rdy),
        .req0_msg  (req0_msg),
        .req1_val  (req1_val),
        .req1_rdy  (req1_rdy),
        .req1_msg  (req1_msg),
        .resp0_val (resp0_val),
        .resp0_rdy (resp0_rdy),
        .resp0_msg (resp0_msg),
        .resp1_val (resp1_val),
        .resp1_rdy (resp1_rdy),
        .resp1_msg (resp1_msg),
        .mul_in0   (mul_in0),
        .mul_in1   (mul_in1),
        .mul_out   (mul_out)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v0, input logic [63:0] m0, input logic v1, input logic [63:0] m1);
        req0_val = v0;
        req0_msg = m0;
        req1_val = v1;
        req1_msg = m1;
    endtask

    // One isolated request on a port with the response consumed immediately.
    task automatic singleTxn(input logic port, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp_prod, input string tag);
        if (port) applyStimulus(1'b0, 64'd0, 1'b1, {a, b});
        else      applyStimulus(1'b1, {a, b}, 1'b0, 64'd0);
        #1;
        checkOutput({tag, "_rdy"}, 32'(port ? req1_rdy : req0_rdy), 32'd1);
        checkOutput({tag, "_other_rdy"}, 32'(port ? req0_rdy : req1_rdy), 32'd0);
        checkOutput({tag, "_mul_in0"}, mul_in0, a);
        checkOutput({tag, "_mul_in1"}, mul_in1, b);
        tick();
        applyStimulus(1'b0, 64'd0, 1'b0, 64'd0);
        checkOutput({tag, "_calc_val"}, 32'(port ? resp1_val : resp0_val), 32'd0);
        checkOutput({tag, "_calc_mul_in0"}, mul_in0, 32'd0);
        tick();
        checkOutput({tag, "_resp_val"}, 32'(port ? resp1_val : resp0_val), 32'd1);
        checkOutput({tag, "_resp_msg"}, port ? resp1_msg : resp0_msg, exp_prod);
        checkOutput({tag, "_other_val"}, 32'(port ? resp0_val : resp1_val), 32'd0);
        tick();
        checkOutput({tag, "_done_val"}, 32'(resp0_val | resp1_val), 32'd0);
    endtask

    initial begin
        reset     = 1'b0;
        resp0_rdy = 1'b1;
        resp1_rdy = 1'b1;
        applyStimulus(1'b0, 64'd0, 1'b0, 64'd0);
        tick();
        tick();
        checkOutput("rst_resp0_val", 32'(resp0_val), 32'd0);
        checkOutput("rst_resp1_val", 32'(resp1_val), 32'd0);
        checkOutput("rst_req0_rdy", 32'(req0_rdy), 32'd0);
        checkOutput("rst_mul_in0", mul_in0, 32'd0);
        checkOutput("rst_resp_msg", resp0_msg, 32'd0);
        reset = 1'b1;
        tick();

        singleTxn(1'b0, 32'd3, 32'd4, 32'd12, "single");
        singleTxn(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, "ovf1");
        singleTxn(1'b0, 32'h8000_0000, 32'd2, 32'h0000_0000, "ovf0");

        // Backpressure: req0 granted, req1 arrives while the response is held.
        applyStimulus(1'b1, {32'd9, 32'd9}, 1'b0, 64'd0);
        #1;
        checkOutput("bp_req0_rdy", 32'(req0_rdy), 32'd1);
        tick();
        applyStimulus(1'b0, 64'd0, 1'b1, {32'd1, 32'd1});
        resp0_rdy = 1'b0;
        checkOutput("bp_calc_req1_rdy", 32'(req1_rdy), 32'd0);
        tick();
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_hold_val", 32'(resp0_val), 32'd1);
            checkOutput("bp_hold_msg", resp0_msg, 32'd81);
            checkOutput("bp_hold_req1_rdy", 32'(req1_rdy), 32'd0);
            tick();
        end
        resp0_rdy = 1'b1;
        tick();
        checkOutput("bp_after_req1_rdy", 32'(req1_rdy), 32'd1);
        checkOutput("bp_after_req0_rdy", 32'(req0_rdy), 32'd0);
        tick();
        applyStimulus(1'b0, 64'd0, 1'b0, 64'd0);
        tick();
        checkOutput("bp_req1_resp_val", 32'(resp1_val), 32'd1);
        checkOutput("bp_req1_resp_msg", resp1_msg, 32'd1);
        tick();

        // Prio hold: req1 alone leaves prio at 0; idle cycles must not move it.
        singleTxn(1'b1, 32'd1, 32'd1, 32'd1, "prio_r1");
        tick();
        tick();
        tick();
        applyStimulus(1'b1, {32'd2, 32'd5}, 1'b1, {32'd7, 32'd6});
        #1;
        checkOutput("prio_req0_rdy", 32'(req0_rdy), 32'd1);
        checkOutput("prio_req1_rdy", 32'(req1_rdy), 32'd0);
        tick();
        applyStimulus(1'b0, 64'd0, 1'b0, 64'd0);
        tick();
        checkOutput("prio_resp0_msg", resp0_msg, 32'd10);
        tick();

        // Reset during CALC abandons the transaction.
        applyStimulus(1'b1, {32'd6, 32'd7}, 1'b0, 64'd0);
        tick();
        applyStimulus(1'b0, 64'd0, 1'b0, 64'd0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checkOutput("midrst_resp0_val", 32'(resp0_val), 32'd0);
            tick();
        end

        // Round-robin with both continuously valid, starting from prio=0.
        applyStimulus(1'b1, {32'd2, 32'd5}, 1'b1, {32'd7, 32'd6});
        for (int k = 0; k < 4; k++) begin
            #1;
            checkOutput("rr_req0_rdy", 32'(req0_rdy), (k % 2 == 0) ? 32'd1 : 32'd0);
            checkOutput("rr_req1_rdy", 32'(req1_rdy), (k % 2 == 1) ? 32'd1 : 32'd0);
            tick();
            tick();
            if (k % 2 == 0) begin
                checkOutput("rr_resp0_val", 32'(resp0_val), 32'd1);
                checkOutput("rr_resp0_msg", resp0_msg, 32'd10);
                checkOutput("rr_resp1_val", 32'(resp1_val), 32'd0);
            end else begin
                checkOutput("rr_resp1_val", 32'(resp1_val), 32'd1);
                checkOutput("rr_resp1_msg", resp1_msg, 32'd42);
                checkOutput("rr_resp0_val", 32'(resp0_val), 32'd0);
            end
            tick();
        end
        applyStimulus(1'b0, 64'd0, 1'b0, 64'd0);
        tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
